// File: rtl/sseg_pkg.sv
// Shared glyph table and idle-level constants for the scanned seven-segment driver.
package sseg_pkg;

   localparam logic [7:0]  SEG_OFF = 8'hFF;
   // Wide enough for the largest supported digit count; users slice it to DIGITS.
   localparam logic [15:0] AN_OFF  = 16'hFFFF;

   // Active-high segments, bit 0 = a ... bit 6 = g; b and d are lower-case glyphs.
   function automatic logic [6:0] hex2seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/sseg_lz_mask.sv
// Leading-zero suppression mask: digit i (i >= 1) is dark when it and every
// more-significant digit hold a zero nibble with no decimal point.
module sseg_lz_mask
   import sseg_pkg::*;
#(
   parameter int DIGITS = 8
) (
   input  logic [DIGITS-1:0][3:0] val,
   input  logic [DIGITS-1:0]      dp,
   output logic [DIGITS-1:0]      lz_mask
);

   logic zero_run;

   // Walk from the most-significant digit down; the run breaks at the first significant digit.
   always_comb begin
      lz_mask  = '0;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run   = zero_run & (val[i] == 4'h0) & ~dp[i];
         lz_mask[i] = zero_run & (i != 0);
      end
   end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Scanned N-digit seven-segment controller with shadowed data, PWM brightness and dead time.
// Optional leading-zero suppression is compiled in with `define SSEG_LZ_SUPPRESS_EN.
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 50000,
   parameter int DIV_W    = $clog2(SCAN_DIV)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic [3:0]            bright,
   output logic [7:0]            seg_n,
   output logic [DIGITS-1:0]     an_n
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [DIGITS-1:0][3:0] val_q, val_d;
   logic [DIGITS-1:0]      dp_q, dp_d;
   logic [DIGITS-1:0]      blank_q, blank_d;
   logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
   logic [IDX_W-1:0]       dig_idx_q, dig_idx_d;
   logic [3:0]             pwm_cnt_q, pwm_cnt_d;
   logic [7:0]             seg_n_q, seg_n_d;
   logic [DIGITS-1:0]      an_n_q, an_n_d;
   logic [DIGITS-1:0]      lz_mask;
   logic                   lit;

`ifdef SSEG_LZ_SUPPRESS_EN
   sseg_lz_mask #(
      .DIGITS  (DIGITS)
   ) u_lz_mask (
      .val     (val_q),
      .dp      (dp_q),
      .lz_mask (lz_mask)
   );
`else
   assign lz_mask = '0;
`endif

   always_comb begin
      val_d   = load ? value : val_q;
      dp_d    = load ? dp    : dp_q;
      blank_d = load ? blank : blank_q;

      div_cnt_d = div_cnt_q + DIV_W'(1);
      dig_idx_d = dig_idx_q;
      if (div_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
         div_cnt_d = '0;
         dig_idx_d = (dig_idx_q == IDX_W'(DIGITS - 1)) ? '0 : dig_idx_q + IDX_W'(1);
      end
      pwm_cnt_d = pwm_cnt_q + 4'd1;
   end

   // Slot start is always dark so the previous digit's cathodes never ghost onto the next anode.
   always_comb begin
      lit = (div_cnt_q != '0) && !blank_q[dig_idx_q] && !lz_mask[dig_idx_q]
            && (pwm_cnt_q <= bright);
      seg_n_d = SEG_OFF;
      an_n_d  = AN_OFF[DIGITS-1:0];
      if (lit) begin
         seg_n_d            = ~{dp_q[dig_idx_q], hex2seg(val_q[dig_idx_q])};
         an_n_d[dig_idx_q]  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_q     <= '0;
         dp_q      <= '0;
         blank_q   <= '1;
         div_cnt_q <= '0;
         dig_idx_q <= '0;
         pwm_cnt_q <= '0;
         seg_n_q   <= SEG_OFF;
         an_n_q    <= AN_OFF[DIGITS-1:0];
      end else begin
         val_q     <= val_d;
         dp_q      <= dp_d;
         blank_q   <= blank_d;
         div_cnt_q <= div_cnt_d;
         dig_idx_q <= dig_idx_d;
         pwm_cnt_q <= pwm_cnt_d;
         seg_n_q   <= seg_n_d;
         an_n_q    <= an_n_d;
      end
   end

   assign seg_n = seg_n_q;
   assign an_n  = an_n_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: two instances (slot lengths 4 and 64) checked every cycle
// against a cycle-count based reference model.
module tb_sseg_scan_ctrl;

   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic        clk;
   logic        rst;
   logic        load;
   logic [31:0] value;
   logic [7:0]  dp;
   logic [7:0]  blank;
   logic [3:0]  bright;
   logic [7:0]  seg_n4, an_n4, seg_n64, an_n64;

   int          n_cmp;
   int          n_bad;

   // Model state: cycles since reset release plus the spec-level shadow copy.
   int unsigned n;
   logic [31:0] m_val;
   logic [7:0]  m_dp;
   logic [7:0]  m_blank;

   sseg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(4)) dut4 (
      .clk (clk), .rst (rst), .load (load), .value (value), .dp (dp),
      .blank (blank), .bright (bright), .seg_n (seg_n4), .an_n (an_n4)
   );

   sseg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(64)) dut64 (
      .clk (clk), .rst (rst), .load (load), .value (value), .dp (dp),
      .blank (blank), .bright (bright), .seg_n (seg_n64), .an_n (an_n64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, n);
      end
   endtask

   // Expected {seg_n, an_n} one cycle after the current model state, for slot length sd.
   function automatic logic [15:0] model(input int unsigned sd);
      int unsigned idx, dv, pw;
      logic [3:0]  nib;
      logic        sup;
      logic        lit;
      idx = (n / sd) % 8;
      dv  = n % sd;
      pw  = n % 16;
      nib = m_val[idx*4 +: 4];
      sup = 1'b0;
`ifdef SSEG_LZ_SUPPRESS_EN
      if (idx >= 1) begin
         sup = 1'b1;
         for (int k = idx; k < 8; k++)
            if (m_val[k*4 +: 4] != 4'h0 || m_dp[k]) sup = 1'b0;
      end
`endif
      lit = (dv != 0) && !m_blank[idx] && !sup && (pw <= int'(bright));
      if (lit) return {~{m_dp[idx], GLYPH[nib]}, ~(8'b1 << idx)};
      return 16'hFFFF;
   endfunction

   task automatic tick();
      logic [15:0] e4, e64;
      e4  = model(4);
      e64 = model(64);
      @(posedge clk);
      #1;
      if (load) begin
         m_val   = value;
         m_dp    = dp;
         m_blank = blank;
      end
      n++;
      chk("seg_n_div4", {8'h00, seg_n4}, {8'h00, e4[15:8]});
      chk("an_n_div4", {8'h00, an_n4}, {8'h00, e4[7:0]});
      chk("seg_n_div64", {8'h00, seg_n64}, {8'h00, e64[15:8]});
      chk("an_n_div64", {8'h00, an_n64}, {8'h00, e64[7:0]});
      chk("an_onehot_div4", {15'd0, ($countones(~an_n4) <= 1)}, 16'd1);
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) tick();
   endtask

   task automatic do_load(input logic [31:0] v, input logic [7:0] d, input logic [7:0] b);
      value = v;
      dp    = d;
      blank = b;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   // Advance the div-4 instance until its internal state is (div, idx).
   task automatic advance_to(input int unsigned dv, input int unsigned idx);
      int guard;
      guard = 0;
      while (!((n % 4) == dv && ((n / 4) % 8) == idx) && guard < 200) begin
         tick();
         guard++;
      end
      if (guard >= 200) begin
         n_bad++;
         $error("FAIL advance_to timeout observed=%0d expected=%0d", n % 32, idx * 4 + dv);
      end
   endtask

   task automatic model_reset();
      n       = 0;
      m_val   = '0;
      m_dp    = '0;
      m_blank = '1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      chk("rst_async_seg", {8'h00, seg_n4}, 16'h00FF);
      chk("rst_async_an", {8'h00, an_n4}, 16'h00FF);
      chk("rst_async_an64", {8'h00, an_n64}, 16'h00FF);
      @(posedge clk);
      #1;
      chk("rst_hold_seg", {8'h00, seg_n64}, 16'h00FF);
      chk("rst_hold_an", {8'h00, an_n4}, 16'h00FF);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int lit_cnt;
      n_cmp  = 0;
      n_bad  = 0;
      rst    = 1'b0;
      load   = 1'b0;
      value  = '0;
      dp     = '0;
      blank  = '0;
      bright = 4'd15;
      model_reset();
      @(posedge clk);
      #1;
      apply_reset();

      // No load after reset: everything stays blank.
      run(64);

      // Full load, full brightness; two complete refreshes on the short-slot instance.
      do_load(32'h1234ABCD, 8'h00, 8'h00);
      run(70);

      // Low nibble blanked, decimal point on digit 4.
      do_load(32'h1234ABCD, 8'h10, 8'h0F);
      run(40);

      // Minimum brightness: the anode may only be low on one cycle in sixteen.
      do_load(32'h89ABCDEF, 8'hA5, 8'h00);
      bright = 4'd0;
      lit_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (an_n64 != 8'hFF) lit_cnt++;
      end
      chk("bright0_lit_le4", {15'd0, (lit_cnt <= 4)}, 16'd1);
      run(80);
      bright = 4'd15;

      // Load while digit 2 is on display, then a load on the slot wrap edge.
      do_load(32'h00000000, 8'h00, 8'h00);
      advance_to(1, 2);
      do_load(32'h00000700, 8'h04, 8'h00);
      run(4);
      advance_to(3, 4);
      do_load(32'hFEDC5000, 8'h00, 8'h00);
      run(8);

      // Leading-zero patterns.
      do_load(32'h00000400, 8'h00, 8'h00);
      run(40);
      do_load(32'h00000000, 8'h00, 8'h00);
      run(40);
      do_load(32'h00000000, 8'h20, 8'h00);
      run(36);

      // Randomized brightness and occasional loads.
      for (int i = 0; i < 400; i++) begin
         bright = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) begin
            logic [31:0] v;
            v = $urandom;
            if ($urandom_range(0, 1) == 1) v = v & 32'h0000_0FFF;
            do_load(v, 8'($urandom_range(0, 255)) & 8'h0F, 8'($urandom_range(0, 255)) & 8'h33);
         end else begin
            tick();
         end
      end

      // Reset in the middle of a lit scan.
      bright = 4'd15;
      do_load(32'h13579BDF, 8'hFF, 8'h00);
      run(6);
      apply_reset();
      run(64);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Multiplexed, parametrised seven-segment display controller for the board top level. It supersedes the fixed two-digit lookup wiring with a scanned N-digit driver for the Nexys DDR anode/cathode display. Features include atomic value loading, per-digit decimal point and blanking, PWM brightness, and ghost-suppression dead time. It sits between CPU-visible debug registers (or top-level glue) and the `SSEG_CA`/`SSEG_AN` pins.

## Interface
Parameters:
- `DIGITS`, 8: number of digits scanned (1..16).
- `SCAN_DIV`, 50000: clock cycles per digit slot (≥4); 50000 at 50 MHz gives a 1 kHz digit rate.
- `DIV_W`, `$clog2(SCAN_DIV)`: prescaler width (derived, not overridden).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `load`  in  1  single-cycle strobe; captures `value`, `dp`, `blank` into the shadow registers.
- `value`  in  4*DIGITS  hex nibbles; digit i is `value[4i+3:4i]`, and digit 0 is rightmost.
- `dp`  in  DIGITS  decimal point enables, 1 = lit.
- `blank`  in  DIGITS  per-digit blank mask, 1 = digit dark.
- `bright`  in  4  brightness level; 15 = full, 0 = 1/16 duty. Sampled live, not shadowed.
- `seg_n`  out  8  active-low cathodes: [0]=a … [6]=g, [7]=dp.
- `an_n`  out  DIGITS  active-low anodes, at most one low at any time.

## Operation
- **Shadow registers:** `val_q`, `dp_q`, `blank_q` load on `clk` when `load`=1. Reset values are 0, 0, and all-ones (all blank).
- **Prescaler:** `div_cnt` counts 0..SCAN_DIV-1. When it reaches SCAN_DIV-1, it wraps to 0 and `dig_idx` advances.
- **Digit index:** `dig_idx` counts 0..DIGITS-1 and wraps to 0. No extra state exists, so non-power-of-two DIGITS must wrap exactly.
- **PWM counter:** `pwm_cnt` is a 4-bit free-running counter, incremented every cycle and wrapping at 15.
- **Anode enable for the current digit:** the anode is driven low only when all of the following hold:
  - `div_cnt != 0` (one-cycle dead time at each slot start to suppress ghosting).
  - `blank_q[dig_idx]` = 0 and the digit is not leading-zero suppressed.
  - `pwm_cnt <= bright`.
- **Cathodes:** `seg_n` = ~{`dp_q[dig_idx]`, hexdecode(nibble)}. Hex glyphs 0–F use standard patterns (b, d lower-case).
- **Dark slots:** when the anode is disabled, `seg_n` = 8'hFF.
- **Load mid-slot:** a `load` takes effect from the following cycle, with no restart of the scan.
- **Simultaneous `load` and slot wrap:** the new shadow data and the new `dig_idx` appear together one cycle later.
- **Reset mid-operation:** all counters are cleared, outputs are forced to all-ones immediately (asynchronous), and the shadow returns to blank.

## Timing
- All outputs are registered, giving one-cycle latency from the internal `dig_idx`/`div_cnt`/`pwm_cnt`/shadow state to `seg_n`/`an_n`.
- Reset value of every output: `seg_n`=8'hFF, `an_n`=all ones.
- First anode assertion after reset release: not before cycle 2 of slot 0, and only after a `load` that un-blanks digit 0.
- A full refresh takes DIGITS*SCAN_DIV cycles. Each digit is lit for at most SCAN_DIV-1 cycles per refresh.
- No back-pressure: `load` is accepted on every cycle it is high.

## Configuration
- Macro: `SSEG_LZ_SUPPRESS_EN`.
- **Defined:** leading-zero suppression is enabled. Digit i (i ≥ 1) is treated as blank when all shadow nibbles i..DIGITS-1 are 0 and `dp_q` is 0 for each of them. Digit 0 is never suppressed. Suppression is computed combinationally from the shadow.
- **Undefined:** no suppression logic is compiled. Only the `blank` mask darkens digits.

## Structure
- Package `sseg_pkg`:
  - function `hex2seg(logic [3:0]) -> logic [6:0]` (active-high a..g).
  - constants `SEG_OFF = 8'hFF` and `AN_OFF`.
- Sub-module `sseg_lz_mask` (combinational, DIGITS-parametrised) produces the suppression mask. It is instantiated only under `SSEG_LZ_SUPPRESS_EN`.
- Everything else lives in `sseg_scan_ctrl`, at roughly 150–250 lines.

## Test plan
All scenarios use DIGITS=8, SCAN_DIV=4 unless noted.
- **Reset state:** assert `rst` mid-scan → `seg_n`=8'hFF and `an_n`=8'hFF in the same cycle. After release with no `load`, `an_n` stays 8'hFF for 64 cycles.
- **Full load:** `load` with `value`=32'h1234ABCD, `dp`=0, `blank`=0, `bright`=15 → each slot shows its digit in turn:
  - slot 0: `an_n`=8'hFE, `seg_n`=~8'h5E ('d'), lit for 3 cycles after 1 dead cycle.
  - slot 7: `an_n`=8'h7F, `seg_n`=~8'h06 ('1').
  - The scan wraps back to digit 0 after 32 cycles.
- **Blank and decimal point:** `blank`=8'h0F, `dp`=8'h10 → `an_n` stays high during slots 0–3. Slot 4 shows `seg_n[7]`=0.
- **Brightness:** `bright`=0, SCAN_DIV=64 → at most 4 lit cycles per slot, and the anode is low only when `pwm_cnt`=0.
- **Load during slot and at wrap:** `load` changing digit 2 while digit 2 is displayed → the new glyph appears on the next cycle. A `load` coinciding with the `div_cnt` wrap shows the new data for the next digit.
- **Leading-zero suppression (with `SSEG_LZ_SUPPRESS_EN`):** `value`=32'h00000400 → digits 3–7 are dark and digits 0–2 show 0, 0, 4. `value`=0 → only digit 0 is lit, showing '0'.
